// File: rtl/cpu_step_4_pkg.sv
// Shared types and constants for the memory-access stage of the CPU pipeline.
package cpu_pkg;
   localparam int DEFAULT_WIDTH = 32;

   // Write-back mux select encoding.
   localparam logic WB_SEL_ALU = 1'b1;
   localparam logic WB_SEL_MEM = 1'b0;

   typedef enum logic {
      IDLE,
      ACCESS
   } mem_state_e;
endpackage

// File: rtl/cpu_step_4_if.sv
// Data-memory request/ready bus between the memory stage and the data memory.
interface cpu_step_4_if #(
   parameter int WIDTH = cpu_pkg::DEFAULT_WIDTH
) ();
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_ready;
   logic [WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/cpu_step_4_mem_fsm.sv
// Handshake FSM: tracks the outstanding memory transaction, drives req/we and the stall.
module cpu_step_4_mem_fsm
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic mem_read,
   input  logic mem_write,
   input  logic mem_ready,
   output logic accept,
   output logic done,
   output logic pass,
   output logic mem_req,
   output logic mem_we,
   output logic stall
);
   mem_state_e state, next_state;
   logic       we_q;
   logic       stall_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         we_q  <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) we_q <= mem_write;
      end
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      done       = 1'b0;
      pass       = 1'b0;
      stall_c    = 1'b0;
      case (state)
         IDLE: begin
            // mem_ready is deliberately ignored here
            if (in_valid && (mem_read || mem_write)) begin
               accept     = 1'b1;
               stall_c    = 1'b1;
               next_state = ACCESS;
            end else if (in_valid) begin
               pass = 1'b1;
            end
         end
         ACCESS: begin
            stall_c = !mem_ready;
            if (mem_ready) begin
               done       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign mem_req = (state == ACCESS);
   assign mem_we  = mem_req && we_q;
   // Stall must vanish the instant reset asserts, even with a memory op still on the inputs.
   assign stall   = stall_c && !rst;
endmodule

// File: rtl/cpu_step_4.sv
// Memory-access stage: request registers, data-memory handshake and step-5 pipeline registers.
module cpu_step_4
   import cpu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int ADDR_WIDTH = $clog2(WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_step_4,
   input  logic [WIDTH-1:0]      out_alu_step_4,
   input  logic [WIDTH-1:0]      store_data_step_4,
   input  logic [ADDR_WIDTH-1:0] rd_step_4,
   input  logic                  control_mem_read,
   input  logic                  control_mem_write,
   input  logic                  control_reg_write,
   input  logic                  control_wb_sel_step_4,
   cpu_step_4_if.master          mem,
   output logic                  stall_step_4,
   output logic                  valid_step_5,
   output logic [WIDTH-1:0]      out_alu_step_5,
   output logic [WIDTH-1:0]      out_memory_step_5,
   output logic [ADDR_WIDTH-1:0] rd_step_5,
   output logic                  reg_write_step_5,
   output logic                  control_mux_for_write_back
);
   logic                  accept, done, pass;
   logic                  req, we;
   logic [WIDTH-1:0]      addr_q, wdata_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic                  reg_write_q, wb_sel_q, load_q;

   cpu_step_4_mem_fsm u_fsm (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_step_4),
      .mem_read  (control_mem_read),
      .mem_write (control_mem_write),
      .mem_ready (mem.mem_ready),
      .accept    (accept),
      .done      (done),
      .pass      (pass),
      .mem_req   (req),
      .mem_we    (we),
      .stall     (stall_step_4)
   );

   assign mem.mem_req   = req;
   assign mem.mem_we    = we;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   // Request registers; the ALU result doubles as the effective address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         wb_sel_q    <= 1'b0;
         load_q      <= 1'b0;
      end else if (accept) begin
         addr_q      <= out_alu_step_4;
         wdata_q     <= store_data_step_4;
         rd_q        <= rd_step_4;
         reg_write_q <= control_reg_write;
         wb_sel_q    <= control_wb_sel_step_4;
         load_q      <= control_mem_read && !control_mem_write;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_step_5               <= 1'b0;
         out_alu_step_5             <= '0;
         out_memory_step_5          <= '0;
         rd_step_5                  <= '0;
         reg_write_step_5           <= 1'b0;
         control_mux_for_write_back <= 1'b0;
      end else if (pass) begin
         valid_step_5               <= 1'b1;
         out_alu_step_5             <= out_alu_step_4;
         out_memory_step_5          <= '0;
         rd_step_5                  <= rd_step_4;
         reg_write_step_5           <= control_reg_write;
         control_mux_for_write_back <= control_wb_sel_step_4;
      end else if (done) begin
         valid_step_5               <= 1'b1;
         out_alu_step_5             <= addr_q;
         out_memory_step_5          <= load_q ? mem.mem_rdata : '0;
         rd_step_5                  <= rd_q;
         reg_write_step_5           <= reg_write_q;
         control_mux_for_write_back <= wb_sel_q;
      end else begin
         // Bubble: data registers keep stale values, but nothing may write back.
         valid_step_5     <= 1'b0;
         reg_write_step_5 <= 1'b0;
      end
   end
endmodule
